// File: rtl/shift_seq_32_if.sv
// shift_seq_32_if -- request/response bundle for the sequential shifter.
//   in_valid/in_ready : request handshake (master -> slave)
//   in_data/in_shamt/in_op : operand, shift amount 0..31, op (00 SLL, 01 SRL, 11 SRA, 10 = SLL)
//   out_valid/out_ready : result handshake (slave -> master)
//   out_data : shifted result
//   busy     : slave is shifting or holding a result
interface shift_seq_32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_seq_32.sv
// shift_seq_32 -- multi-cycle 32-bit shifter (SLL/SRL/SRA), at most STEP bit
// positions per cycle.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : shift_seq_32_if.slave (request, result and busy signals)
//   perf_count : 16-bit saturating count of result handshakes; present only
//                when SHIFT_SEQ_PERF_EN is defined
// Parameter STEP: 1, 2, 4 or 8.

// One-hot selected shift stage: sel[k] picks a shift by k positions.
module shift_seq_32_stage #(
  parameter int STEP = 4
) (
  input  logic [31:0]   din,
  input  logic [STEP:0] sel,
  input  logic          right,
  input  logic          fill,
  output logic [31:0]   dout
);
  logic [STEP:0][31:0] cand;

  genvar k;
  generate
    for (k = 0; k <= STEP; k++) begin : g_cand
      if (k == 0) begin : g_zero
        assign cand[k] = din;
      end else begin : g_sh
        assign cand[k] = right ? {{k{fill}}, din[31:k]} : {din[31-k:0], {k{1'b0}}};
      end
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int i = 0; i <= STEP; i++)
      if (sel[i]) dout = dout | cand[i];
  end
endmodule

module shift_seq_32 #(
  parameter int STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_seq_32_if.slave       bus
`ifdef SHIFT_SEQ_PERF_EN
  ,
  output logic [15:0]         perf_count
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      state;
  logic [31:0] work;
  logic [31:0] out_q;
  logic [4:0]  remaining;
  logic [1:0]  op;
  logic        sign;
  logic        in_ready_q, out_valid_q, busy_q;

  logic [4:0]    step;
  logic [STEP:0] step_oh;
  logic [31:0]   shifted;
  logic          right, fill;

  // Per-cycle amount: min(remaining, STEP), delivered one-hot.
  assign step = (remaining < STEP5) ? remaining : STEP5;

  genvar k;
  generate
    for (k = 0; k <= STEP; k++) begin : g_oh
      assign step_oh[k] = (step == 5'(k));
    end
  endgenerate

  // op[0] selects a right shift (01, 11); 00 and 10 are both left shifts.
  // Only SRA fills with the sign bit latched at acceptance.
  assign right = op[0];
  assign fill  = op[1] & op[0] & sign;

  shift_seq_32_stage #(.STEP(STEP)) u_stage (
    .din   (work),
    .sel   (step_oh),
    .right (right),
    .fill  (fill),
    .dout  (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      work        <= '0;
      out_q       <= '0;
      remaining   <= '0;
      op          <= '0;
      sign        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          work       <= bus.in_data;
          op         <= bus.in_op;
          sign       <= bus.in_data[31];
          remaining  <= bus.in_shamt;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          if (bus.in_shamt == 5'd0) begin
            state       <= DONE;
            out_q       <= bus.in_data;
            out_valid_q <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work      <= shifted;
          remaining <= remaining - step;
          if (remaining == step) begin
            state       <= DONE;
            out_q       <= shifted;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          // in_ready only rises after this edge, so no same-cycle accept.
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;

`ifdef SHIFT_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_count <= '0;
    else if (state == DONE && bus.out_ready && perf_count != 16'hFFFF)
      perf_count <= perf_count + 16'd1;
  end
`endif
endmodule

// File: doc/shift_seq_32.md
SHIFT_SEQ_32 -- requirements
Module: shift_seq_32

Interface
REQ-001 SHALL provide parameter STEP, default 4: maximum bit positions shifted per SHIFT cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL provide port in_valid, input, 1: request present.
REQ-005 SHALL provide port in_ready, output, 1: block can accept a request.
REQ-006 SHALL provide port in_data, input, 32: operand.
REQ-007 SHALL provide port in_shamt, input, 5: binary shift amount, 0..31.
REQ-008 SHALL provide port in_op, input, 2: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
REQ-009 SHALL provide port out_valid, output, 1: result present.
REQ-010 SHALL provide port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL provide port out_data, output, 32: shifted result.
REQ-012 SHALL provide port busy, output, 1: high in SHIFT or DONE.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = !in_ready.
REQ-014 SHALL, on in_valid && in_ready at edge T, latch in_data, in_op and remaining = in_shamt.
REQ-015 SHALL go from IDLE to DONE when the accepted in_shamt==0, with out_data = in_data.
REQ-016 SHALL go from IDLE to SHIFT when the accepted in_shamt!=0.
REQ-017 SHALL, each SHIFT cycle, shift the working register by step = min(remaining, STEP) and subtract step from remaining.
REQ-018 SHALL drive the per-cycle amount internally as a one-hot vector (bit step set) to a one-hot shift stage.
REQ-019 SHALL go from SHIFT to DONE on the edge where remaining reaches 0.
REQ-020 SHALL assert out_valid from T+1 for shamt 0, and from T+1+ceil(shamt/STEP) otherwise.
REQ-021 SHALL zero-fill for SLL and SRL, and fill with the latched bit 31 for SRA on every step.
REQ-022 SHALL treat op 2'b10 exactly as SLL.
REQ-023 SHALL hold out_data stable while out_valid && !out_ready.
REQ-024 SHALL return to IDLE on the edge where out_valid && out_ready; out_valid and out_data SHALL change only on that edge.
REQ-025 SHALL NOT accept a new request in the same cycle as the DONE handshake; in_ready rises the following cycle.
REQ-026 SHALL ignore in_data, in_shamt and in_op changes while busy.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0 and remaining=0, independent of clk.
REQ-028 SHALL discard any in-flight operation on reset assertion mid-SHIFT or mid-DONE, with no result delivered.
REQ-029 SHALL accept a request on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro SHIFT_SEQ_PERF_EN defined, add output perf_count, 16 bits: count of DONE handshakes; resets to 0 and saturates at 16'hFFFF.
REQ-031 SHALL, without SHIFT_SEQ_PERF_EN, omit the perf_count port and counter logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: STEP=4, SLL 32'h0000_0001, shamt 5 -> out_data 32'h0000_0020, out_valid at T+3.
REQ-033 SHALL cover: SRA 32'h8000_0000, shamt 31 -> 32'hFFFF_FFFF at T+9; SRL of the same operand -> 32'h0000_0001.
REQ-034 SHALL cover: shamt 0, data 32'hDEAD_BEEF, op SRA -> 32'hDEAD_BEEF at T+1.
REQ-035 SHALL cover: out_ready low for 5 cycles in DONE -> out_valid and out_data held; in_ready stays 0; in_data toggled with no effect.
REQ-036 SHALL cover: rst pulsed mid-SHIFT of a shamt 20 op -> in the same cycle out_valid=0, in_ready=1; next request completes correctly.
REQ-037 SHALL cover: with SHIFT_SEQ_PERF_EN, 3 back-to-back ops -> perf_count=3; after rst perf_count=0.
